// File: rtl/mii_tx_arb_pkg.sv
// Shared types and constants for the MII transmit arbiter.
// Holds the FSM state encodings, the preamble/SFD nibble values, the byte
// counter width and the payload of one two-nibble byte slot.
package mii_tx_arb_pkg;

   localparam int unsigned STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PREAMBLE = 3'd1;
   localparam logic [2:0] ST_DATA     = 3'd2;
   localparam logic [2:0] ST_PAD      = 3'd3;
   localparam logic [2:0] ST_IFG      = 3'd4;

   localparam logic [3:0] PREAMBLE_NIBBLE = 4'h5;
   localparam logic [3:0] SFD_NIBBLE      = 4'hD;
   localparam int unsigned PREAMBLE_CYCLES = 16;

   localparam int unsigned BYTE_CNT_W = 11;
   typedef logic [BYTE_CNT_W-1:0] byte_cnt_t;

   // One byte slot on the wire; an underrun slot carries data 0 with err set.
   typedef struct packed {
      logic [7:0] data;
      logic       last;
      logic       err;
   } slot_t;

   // Saturating increment for the frame byte counter.
   function automatic byte_cnt_t sat_inc(input byte_cnt_t c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (request vector), last (previously granted index),
//        grant (one-hot, zero when no request), index (encoded winner,
//        equal to last when nothing requests).
// Search starts at last+1 and wraps, so last itself has lowest priority.
module rr_arbiter #(
   parameter int unsigned PORTS = 2
) (
   input  logic [PORTS-1:0]         req,
   input  logic [$clog2(PORTS)-1:0] last,
   output logic [PORTS-1:0]         grant,
   output logic [$clog2(PORTS)-1:0] index
);

   localparam int unsigned IW = $clog2(PORTS);

   always_comb begin
      logic        found;
      int unsigned p;
      found = 1'b0;
      p     = 0;
      grant = '0;
      index = last;
      for (int unsigned i = 1; i <= PORTS; i++) begin
         p = (32'(last) + i) % PORTS;
         if (!found && req[IW'(p)]) begin
            found           = 1'b1;
            grant[IW'(p)]   = 1'b1;
            index           = IW'(p);
         end
      end
   end

endmodule

// File: rtl/mii_tx_arbiter.sv
// Shares one MII transmit interface between PORTS byte-stream sources.
// Grants whole frames round-robin, emits preamble + SFD, serialises each
// byte low nibble first and enforces the inter-frame gap.
// Ports: clk/rst_n (sync, active-low); s_tdata/s_tvalid/s_tready/s_tlast/
//        s_tuser per-port byte streams (s_tuser = abort on tlast byte);
//        mii_txd/mii_tx_en/mii_tx_er to the PHY; busy (not IDLE);
//        active_port (current or last grant).
// Build option: define MII_TX_ARB_PAD_EN to pad short frames with zero
// bytes up to MIN_FRAME_LEN; without it short frames go out as-is.
module mii_tx_arbiter
   import mii_tx_arb_pkg::*;
#(
   parameter int unsigned PORTS         = 2,
   parameter int unsigned IFG_NIBBLES   = 24,
   parameter int unsigned MIN_FRAME_LEN = 60
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [PORTS*8-1:0]       s_tdata,
   input  logic [PORTS-1:0]         s_tvalid,
   output logic [PORTS-1:0]         s_tready,
   input  logic [PORTS-1:0]         s_tlast,
   input  logic [PORTS-1:0]         s_tuser,
   output logic [3:0]               mii_txd,
   output logic                     mii_tx_en,
   output logic                     mii_tx_er,
   output logic                     busy,
   output logic [$clog2(PORTS)-1:0] active_port
);

   localparam int unsigned IW    = $clog2(PORTS);
   localparam int unsigned PRE_W = $clog2(PREAMBLE_CYCLES);
   localparam int unsigned IFG_W = $clog2(IFG_NIBBLES + 1);

   state_t           state, state_n;
   logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
   logic [IFG_W-1:0] ifg_cnt, ifg_cnt_n;
   logic             hi, hi_n;
   slot_t            slot, slot_n;
   byte_cnt_t        byte_cnt, byte_cnt_n;
   logic [3:0]       txd_n;
   logic             en_n, er_n, busy_n;
   logic [PORTS-1:0] tready_n;
   logic [IW-1:0]    port_n;

   logic [PORTS-1:0] grant_c;
   logic [IW-1:0]    arb_idx_c;
   logic [PORTS-1:0] onehot_c;
   logic [7:0]       byte_c;
   logic             valid_c, last_c, user_c;

   // Arbitration pointer is the registered active_port.
   rr_arbiter #(.PORTS(PORTS)) u_arb (
      .req   (s_tvalid),
      .last  (active_port),
      .grant (grant_c),
      .index (arb_idx_c)
   );

   // Granted port's stream, selected by the held grant.
   assign onehot_c = PORTS'(1) << active_port;
   assign byte_c   = s_tdata[{active_port, 3'b000} +: 8];
   assign valid_c  = s_tvalid[active_port];
   assign last_c   = s_tlast[active_port];
   assign user_c   = s_tuser[active_port];

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pre_cnt     <= '0;
         ifg_cnt     <= '0;
         hi          <= 1'b0;
         slot        <= '0;
         byte_cnt    <= '0;
         mii_txd     <= '0;
         mii_tx_en   <= 1'b0;
         mii_tx_er   <= 1'b0;
         s_tready    <= '0;
         busy        <= 1'b0;
         active_port <= IW'(PORTS - 1);
      end else begin
         state       <= state_n;
         pre_cnt     <= pre_cnt_n;
         ifg_cnt     <= ifg_cnt_n;
         hi          <= hi_n;
         slot        <= slot_n;
         byte_cnt    <= byte_cnt_n;
         mii_txd     <= txd_n;
         mii_tx_en   <= en_n;
         mii_tx_er   <= er_n;
         s_tready    <= tready_n;
         busy        <= busy_n;
         active_port <= port_n;
      end
   end

   // Next state and next registered outputs for the following nibble.
   always_comb begin
      logic start_frame, begin_slot, enter_ifg;
      state_n     = state;
      pre_cnt_n   = pre_cnt;
      ifg_cnt_n   = ifg_cnt;
      hi_n        = hi;
      slot_n      = slot;
      byte_cnt_n  = byte_cnt;
      txd_n       = '0;
      en_n        = 1'b0;
      er_n        = 1'b0;
      busy_n      = 1'b1;
      tready_n    = '0;
      port_n      = active_port;
      start_frame = 1'b0;
      begin_slot  = 1'b0;
      enter_ifg   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (|grant_c) start_frame = 1'b1;
            else          busy_n      = 1'b0;
         end
         ST_PREAMBLE: begin
            en_n = 1'b1;
            if (pre_cnt == PRE_W'(PREAMBLE_CYCLES - 1)) begin
               begin_slot = 1'b1;
            end else begin
               pre_cnt_n = pre_cnt + 1'b1;
               if (pre_cnt == PRE_W'(PREAMBLE_CYCLES - 2)) begin
                  txd_n    = SFD_NIBBLE;
                  tready_n = onehot_c;
               end else begin
                  txd_n = PREAMBLE_NIBBLE;
               end
            end
         end
         ST_DATA: begin
            en_n = 1'b1;
            if (!hi) begin
               hi_n  = 1'b1;
               txd_n = slot.data[7:4];
               er_n  = slot.err;
               if (!slot.last) tready_n = onehot_c;
            end else if (slot.last) begin
               enter_ifg = 1'b1;
`ifdef MII_TX_ARB_PAD_EN
               if (byte_cnt < BYTE_CNT_W'(MIN_FRAME_LEN)) begin
                  enter_ifg  = 1'b0;
                  state_n    = ST_PAD;
                  hi_n       = 1'b0;
                  byte_cnt_n = sat_inc(byte_cnt);
               end
`endif
            end else begin
               begin_slot = 1'b1;
            end
         end
`ifdef MII_TX_ARB_PAD_EN
         ST_PAD: begin
            // Zero bytes, counted at the start of each slot.
            en_n = 1'b1;
            hi_n = !hi;
            if (hi) begin
               if (byte_cnt >= BYTE_CNT_W'(MIN_FRAME_LEN)) enter_ifg  = 1'b1;
               else                                       byte_cnt_n = sat_inc(byte_cnt);
            end
         end
`endif
         ST_IFG: begin
            // Last gap nibble doubles as arbitration so back-to-back gaps are exact.
            if (ifg_cnt == IFG_W'(IFG_NIBBLES - 1)) begin
               if (|grant_c) begin
                  start_frame = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  busy_n  = 1'b0;
               end
            end else begin
               ifg_cnt_n = ifg_cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            busy_n  = 1'b0;
         end
      endcase

      if (start_frame) begin
         state_n    = ST_PREAMBLE;
         pre_cnt_n  = '0;
         byte_cnt_n = '0;
         port_n     = arb_idx_c;
         txd_n      = PREAMBLE_NIBBLE;
         en_n       = 1'b1;
         busy_n     = 1'b1;
      end

      // Handshake completed in this cycle (or underrun): open a new byte slot.
      if (begin_slot) begin
         state_n = ST_DATA;
         hi_n    = 1'b0;
         if (valid_c) begin
            slot_n     = '{data: byte_c, last: last_c, err: last_c & user_c};
            byte_cnt_n = sat_inc(byte_cnt);
         end else begin
            slot_n = '{data: 8'h00, last: 1'b0, err: 1'b1};
         end
         txd_n = slot_n.data[3:0];
         er_n  = slot_n.err;
         en_n  = 1'b1;
      end

      if (enter_ifg) begin
         state_n   = ST_IFG;
         ifg_cnt_n = '0;
         txd_n     = '0;
         en_n      = 1'b0;
         er_n      = 1'b0;
      end
   end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: per-port byte sources fed from queues,
// a wire monitor that captures each tx_en burst, and hand-computed checks.
module tb_mii_tx_arbiter;

   localparam int PORTS = 2;
   localparam int IFG   = 24;
   localparam int MAXF  = 16;
   localparam int MAXN  = 160;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [PORTS*8-1:0] s_tdata;
   logic [PORTS-1:0]   s_tvalid, s_tready, s_tlast, s_tuser;
   logic [3:0]         mii_txd;
   logic               mii_tx_en, mii_tx_er, busy;
   logic [0:0]         active_port;

   mii_tx_arbiter #(.PORTS(PORTS), .IFG_NIBBLES(IFG), .MIN_FRAME_LEN(60)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_tdata     (s_tdata),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tlast     (s_tlast),
      .s_tuser     (s_tuser),
      .mii_txd     (mii_txd),
      .mii_tx_en   (mii_tx_en),
      .mii_tx_er   (mii_tx_er),
      .busy        (busy),
      .active_port (active_port)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       user;
      logic       hole;
   } ent_t;

   ent_t q [PORTS][$];
   int   v_rise [PORTS];
   int   total = 0;
   int   bad   = 0;

   // Monitor storage.
   int         fcnt = 0;
   bit         in_f = 0;
   int         f_len [MAXF];
   int         f_port[MAXF];
   int         f_start[MAXF];
   int         f_end [MAXF];
   int         f_er  [MAXF];
   logic [3:0] f_nib [MAXF][MAXN];
   logic       f_erb [MAXF][MAXN];
   int         b_fall = 0;
   logic       busy_d = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic add_byte(input int p, input logic [7:0] d, input bit l, input bit u);
      ent_t e;
      e.data = d; e.last = l; e.user = u; e.hole = 1'b0;
      q[p].push_back(e);
   endtask

   task automatic add_hole(input int p);
      ent_t e;
      e.data = 8'h00; e.last = 1'b0; e.user = 1'b0; e.hole = 1'b1;
      q[p].push_back(e);
   endtask

   // Source driver: handshake judged on the ready seen during the cycle.
   initial begin
      logic [PORTS-1:0] rdy;
      s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_tuser = '0;
      forever begin
         @(negedge clk);
         rdy = s_tready;
         @(posedge clk);
         #1;
         for (int p = 0; p < PORTS; p++) begin
            if (rdy[p] && q[p].size() > 0) void'(q[p].pop_front());
            if (q[p].size() > 0) begin
               if (!s_tvalid[p] && !q[p][0].hole) v_rise[p] = cyc;
               s_tvalid[p]        = !q[p][0].hole;
               s_tdata[8*p +: 8]  = q[p][0].data;
               s_tlast[p]         = q[p][0].last;
               s_tuser[p]         = q[p][0].user;
            end else begin
               s_tvalid[p] = 1'b0;
               s_tlast[p]  = 1'b0;
               s_tuser[p]  = 1'b0;
            end
         end
      end
   end

   // Wire monitor: one record per tx_en burst.
   initial begin
      forever begin
         @(negedge clk);
         if (mii_tx_en) begin
            if (!in_f) begin
               in_f          = 1;
               f_len[fcnt]   = 0;
               f_er[fcnt]    = 0;
               f_start[fcnt] = cyc;
               f_port[fcnt]  = int'(active_port);
            end
            if (f_len[fcnt] < MAXN) begin
               f_nib[fcnt][f_len[fcnt]] = mii_txd;
               f_erb[fcnt][f_len[fcnt]] = mii_tx_er;
            end
            f_len[fcnt]++;
            if (mii_tx_er) f_er[fcnt]++;
            f_end[fcnt] = cyc;
         end else if (in_f) begin
            in_f = 0;
            if (fcnt < MAXF - 1) fcnt++;
         end
         if (busy_d && !busy) b_fall = cyc;
         busy_d = busy;
      end
   end

   task automatic sync();
      @(negedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int p = 0; p < PORTS; p++) q[p].delete();
      sync();
      sync();
      rst_n = 1'b1;
      fcnt  = 0;
   endtask

   task automatic wait_frames(input int n, input int budget, input string tag);
      int k;
      k = 0;
      while (!(fcnt >= n && !in_f && !busy) && k < budget) begin
         sync();
         k++;
      end
      if (k >= budget) check({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_bytes(input int f, input string tag, input logic [7:0] b[$]);
      for (int k = 0; k < b.size(); k++)
         check($sformatf("%s_b%0d", tag, k), {f_nib[f][17+2*k], f_nib[f][16+2*k]}, b[k]);
   endtask

   task automatic check_frame(input int f, input string tag, input logic [7:0] b[$]);
      logic [63:0] pre;
      pre = '0;
      check({tag, "_len"}, f_len[f], 16 + 2 * b.size());
      for (int i = 0; i < 16; i++) pre = {pre[59:0], f_nib[f][i]};
      check({tag, "_pre"}, pre, 64'h555555555555555D);
      check_bytes(f, tag, b);
      check({tag, "_er"}, f_er[f], 0);
   endtask

   initial begin
      logic [7:0] b[$];
      int         k;
      int         exp_port[4];
      logic [7:0] e3[6];

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      // Reset values.
      check("rst_txd", mii_txd, 0);
      check("rst_en", mii_tx_en, 0);
      check("rst_er", mii_tx_er, 0);
      check("rst_tready", s_tready, 0);
      check("rst_busy", busy, 0);
      check("rst_port", active_port, 1);
      #2 rst_n = 1'b1;
      sync();

      // Single 4-byte frame on port 0.
      fcnt = 0;
      add_byte(0, 8'h11, 0, 0); add_byte(0, 8'h22, 0, 0);
      add_byte(0, 8'h33, 0, 0); add_byte(0, 8'h44, 1, 0);
      wait_frames(1, 300, "t1");
      b = {8'h11, 8'h22, 8'h33, 8'h44};
      check_frame(0, "t1", b);
      check("t1_latency", f_start[0] - v_rise[0], 1);
      check("t1_port", f_port[0], 0);
      check("t1_ifg", b_fall - f_end[0], IFG + 1);

      // Simultaneous requests, two frames per port.
      do_reset();
      add_byte(0, 8'h01, 0, 0); add_byte(0, 8'h02, 1, 0); add_byte(0, 8'h03, 1, 0);
      add_byte(1, 8'h81, 0, 0); add_byte(1, 8'h82, 1, 0); add_byte(1, 8'h83, 1, 0);
      wait_frames(4, 800, "t2");
      exp_port = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) check($sformatf("t2_port%0d", i), f_port[i], exp_port[i]);
      for (int i = 0; i < 3; i++) check($sformatf("t2_gap%0d", i), f_start[i+1] - f_end[i] - 1, IFG);
      b = {8'h01, 8'h02}; check_frame(0, "t2f0", b);
      b = {8'h81, 8'h82}; check_frame(1, "t2f1", b);
      b = {8'h03};        check_frame(2, "t2f2", b);
      b = {8'h83};        check_frame(3, "t2f3", b);

      // Underrun after byte 2 of a 5-byte frame on port 1.
      fcnt = 0;
      add_byte(1, 8'h21, 0, 0); add_byte(1, 8'h43, 0, 0); add_hole(1);
      add_byte(1, 8'h65, 0, 0); add_byte(1, 8'h87, 0, 0); add_byte(1, 8'hA9, 1, 0);
      wait_frames(1, 300, "t3");
      e3 = '{8'h21, 8'h43, 8'h00, 8'h65, 8'h87, 8'hA9};
      check("t3_len", f_len[0], 16 + 12);
      check("t3_er", f_er[0], 2);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t3_b%0d", i), {f_nib[0][17+2*i], f_nib[0][16+2*i]}, e3[i]);
         check($sformatf("t3_erb%0d", i), {f_erb[0][17+2*i], f_erb[0][16+2*i]}, (i == 2) ? 2'b11 : 2'b00);
      end

      // Aborted frame: tlast byte with tuser.
      fcnt = 0;
      add_byte(0, 8'h12, 0, 0); add_byte(0, 8'hAB, 1, 1);
      wait_frames(1, 300, "t4");
      check("t4_len", f_len[0], 20);
      b = {8'h12, 8'hAB}; check_bytes(0, "t4", b);
      check("t4_er_lo", {f_erb[0][17], f_erb[0][16]}, 2'b00);
      check("t4_er_ab", {f_erb[0][19], f_erb[0][18]}, 2'b11);
      check("t4_ifg", b_fall - f_end[0], IFG + 1);

      // 10-byte frame: padded to 60 bytes only when padding is built in.
      fcnt = 0;
      b = {};
      for (int i = 1; i <= 10; i++) begin
         add_byte(1, 8'(i), (i == 10), 0);
         b.push_back(8'(i));
      end
      wait_frames(1, 600, "t5");
`ifdef MII_TX_ARB_PAD_EN
      check("t5_len", f_len[0], 16 + 120);
      check_bytes(0, "t5", b);
      check("t5_pad_first", {f_nib[0][37], f_nib[0][36]}, 0);
      check("t5_pad_last", {f_nib[0][135], f_nib[0][134]}, 0);
      check("t5_er", f_er[0], 0);
`else
      check_frame(0, "t5", b);
`endif

      // Reset pulse in the middle of DATA.
      fcnt = 0;
      for (int i = 0; i < 8; i++) add_byte(0, 8'hC0 + 8'(i), (i == 7), 0);
      k = 0;
      while (!(in_f && f_len[fcnt] >= 20) && k < 200) begin
         sync();
         k++;
      end
      if (k >= 200) check("t6_start_timeout", 0, 1);
      rst_n = 1'b0;
      for (int p = 0; p < PORTS; p++) q[p].delete();
      @(negedge clk);
      check("t6_en", mii_tx_en, 0);
      check("t6_tready", s_tready, 0);
      check("t6_busy", busy, 0);
      check("t6_er", mii_tx_er, 0);
      check("t6_port", active_port, 1);
      #2;
      rst_n = 1'b1;
      fcnt  = 0;
      add_byte(0, 8'h5A, 1, 0);
      add_byte(1, 8'hC3, 1, 0);
      wait_frames(2, 400, "t6");
      check("t6_latency", f_start[0] - v_rise[0], 1);
      check("t6_first_port", f_port[0], 0);
      check("t6_second_port", f_port[1], 1);
      b = {8'h5A}; check_frame(0, "t6f0", b);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mii_tx_arbiter.md
# mii_tx_arbiter

Shares one MII transmit interface between `PORTS` byte-stream frame sources. Grants whole frames round-robin, inserts preamble/SFD, serialises bytes to nibbles (low nibble first) and enforces the inter-frame gap. Sits between MAC-side frame sources and the PHY `phy_txd`/`phy_tx_en`/`phy_tx_er` pins, clocked by the PHY transmit clock.

## Interface
- `PORTS`, 2: number of frame sources (2..8).
- `IFG_NIBBLES`, 24: idle nibble cycles enforced after each frame (12 byte times).
- `MIN_FRAME_LEN`, 60: minimum payload bytes; used only with padding compiled in.
- `clk`  in  1  MII transmit clock (`phy_tx_clk`); one nibble per cycle.
- `rst_n`  in  1  Reset. One clock; reset is synchronous and active-low.
- `s_tdata`  in  PORTS*8  per-port byte; port i at bits [8i+7:8i].
- `s_tvalid`  in  PORTS  per-port byte valid.
- `s_tready`  out  PORTS  per-port byte accept; one-hot or zero.
- `s_tlast`  in  PORTS  last byte of frame.
- `s_tuser`  in  PORTS  abort flag, sampled with the `tlast` byte.
- `mii_txd`  out  4  nibble to PHY.
- `mii_tx_en`  out  1  transmit enable.
- `mii_tx_er`  out  1  transmit error.
- `busy`  out  1  high in any state other than IDLE.
- `active_port`  out  $clog2(PORTS)  currently/last granted port.

## Operation
- States: IDLE, PREAMBLE, DATA, PAD (macro only), IFG.
- IDLE: if any `s_tvalid`, grant the first requesting port strictly after the last granted port (round-robin); go to PREAMBLE. No request: stay.
- PREAMBLE: 16 cycles; `mii_txd` = 0x5 for 15 cycles, then 0xD (SFD). `mii_tx_en`=1, `mii_tx_er`=0.
- Byte slot: two cycles, low nibble then high nibble. `s_tready[g]` is high in the SFD cycle and in each high-nibble cycle of DATA, unless the current byte was `tlast`. A byte is transferred when `s_tvalid[g] && s_tready[g]`; it is driven in the next two cycles.
- Underrun (`s_tvalid[g]` low when `s_tready[g]` high): next slot drives `mii_txd`=0, `mii_tx_en`=1, `mii_tx_er`=1 for both nibbles; `s_tready` is offered again at that slot's end. The frame continues; it is corrupt.
- Abort: a `tlast` byte with `s_tuser[g]`=1 is driven with `mii_tx_er`=1 on both nibbles.
- After the `tlast` byte's high nibble: go to IFG (or PAD). IFG: `mii_tx_en`=0, `mii_txd`=0 for `IFG_NIBBLES` cycles, then IDLE.
- Grant does not change mid-frame; other ports' `s_tready` stay 0.
- Byte counter: 11 bits, saturates at 2047; counts bytes driven in DATA.

## Timing
- All outputs registered. Reset values: `mii_txd`=0, `mii_tx_en`=0, `mii_tx_er`=0, `s_tready`=0, `busy`=0, `active_port`=PORTS-1 (so port 0 wins first).
- `s_tvalid` seen in IDLE at cycle t: first preamble nibble on `mii_txd` at t+1; SFD at t+16; first data nibble at t+17.
- Back-to-back frames: `mii_tx_en` low for exactly `IFG_NIBBLES` cycles.
- Simultaneous requests on all ports: served in order last+1, last+2, … wrapping at PORTS-1→0.
- `rst_n` low mid-frame: all outputs at reset values after the next edge; no IFG is inserted; arbitration pointer resets.

## Configuration
- `MII_TX_ARB_PAD_EN` defined: if `tlast` arrives with byte count < `MIN_FRAME_LEN`, enter PAD and drive 0x00 bytes (`mii_tx_en`=1, `mii_tx_er`=0) until the count reaches `MIN_FRAME_LEN`, then IFG. `s_tready` is 0 in PAD.
- Not defined: PAD state and `MIN_FRAME_LEN` logic are absent; short frames are sent as-is.

## Structure
- Package `mii_tx_arb_pkg`: state enum, `PREAMBLE_NIBBLE`=4'h5, `SFD_NIBBLE`=4'hD, `PREAMBLE_CYCLES`=16, byte counter width.
- One sub-module: `rr_arbiter` (PORTS-wide request vector, last-grant pointer in, one-hot grant and encoded index out; combinational).

## Test plan
- Port 0 sends 4-byte frame 0x11,0x22,0x33,0x44 (no macro) → 15×0x5, 0xD, then 1,1,2,2,3,3,4,4 on `mii_txd`; `mii_tx_en` high 24 cycles; then 24 idle cycles.
- Ports 0 and 1 request simultaneously after reset, each sending 2 frames → frame order 0,1,0,1; gap between frames exactly 24 cycles.
- `s_tvalid` dropped for one slot after byte 2 of a 5-byte frame → one 2-cycle slot with `mii_tx_er`=1, `mii_txd`=0; remaining bytes follow; total `mii_tx_en` high 16+12 cycles.
- `tlast` byte 0xAB with `s_tuser`=1 → nibbles B,A driven with `mii_tx_er`=1; IFG follows.
- With `MII_TX_ARB_PAD_EN`, 10-byte frame → 50 zero bytes appended; `mii_tx_en` high 16+120 cycles.
- `rst_n` low during DATA for one cycle → next cycle `mii_tx_en`=0, `s_tready`=0, `busy`=0; a new request then starts preamble within 1 cycle.
